swap_ctrl: RTL and testbench

SWAP_CTRL -- requirements
Module: swap_ctrl

---
 rtl/swap_ctrl_pkg.sv | 30 +++
 rtl/swap_ctrl.sv | 83 ++++++++
 tb/tb_swap_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/swap_ctrl_pkg.sv
// Shared types and constants for the memory swap controller.
package swap_ctrl_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] SEL_A    = 2'd0;
    localparam logic [1:0] SEL_B    = 2'd1;
    localparam logic [1:0] SEL_HOST = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP_B,
        WR_A,
        WR_B,
        DONE
    } state_t;

    // Address mux selection presented while the FSM sits in a given state.
    function automatic logic [1:0] sel_for(input state_t s);
        case (s)
            RD_A, WR_A:        sel_for = SEL_A;
            RD_B, CAP_B, WR_B: sel_for = SEL_B;
            default:           sel_for = SEL_HOST;
        endcase
    endfunction

endpackage

// File: rtl/swap_ctrl.sv
// Swaps the contents of two memory words through a shared external address mux.
// Every output is registered from the next-state value, so it lines up with the state register.
module swap_ctrl
    import swap_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [1:0]        mux_sel,
    output logic [ADDR_W-1:0] addr_a_q,
    output logic [ADDR_W-1:0] addr_b_q,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        swap_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] tmp_a;
    logic [DATA_W-1:0] tmp_b;

    // NOTE: the default assignment first keeps every path covered, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (addr_a == addr_b) ? DONE : RD_A;
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = CAP_B;
            CAP_B:   state_nxt = WR_A;
            WR_A:    state_nxt = WR_B;
            WR_B:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mux_sel  <= SEL_HOST;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            swap_cnt <= 8'd0;
            tmp_a    <= '0;
            tmp_b    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            state   <= state_nxt;
            mux_sel <= sel_for(state_nxt);
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == DONE);
            wr_en   <= (state_nxt == WR_A) || (state_nxt == WR_B);

            if (state == IDLE && start) begin
                addr_a_q <= addr_a;
                addr_b_q <= addr_b;
            end
            if (state == RD_B)  tmp_a <= rd_data;
            if (state == CAP_B) tmp_b <= rd_data;
            if (state == DONE && swap_cnt != 8'hFF) swap_cnt <= swap_cnt + 8'd1;

            // WR_A is entered on the same edge that captures tmp_b, so forward rd_data directly.
            case (state_nxt)
                WR_A:    wr_data <= rd_data;
                WR_B:    wr_data <= tmp_a;
                default: wr_data <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_swap_ctrl.sv
// Directed bench: swap_ctrl driving a behavioural 4:1 address mux and synchronous-read memory.
module tb_swap_ctrl;
    import swap_ctrl_pkg::*;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [AW-1:0] addr_b = '0;
    logic [1:0]    mux_sel;
    logic [AW-1:0] addr_a_q;
    logic [AW-1:0] addr_b_q;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic [7:0]    swap_cnt;

    swap_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .mux_sel  (mux_sel),
        .addr_a_q (addr_a_q),
        .addr_b_q (addr_b_q),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .swap_cnt (swap_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: host address is 0, read data appears one cycle after the address.
    logic [DW-1:0] mem [32];
    logic          mem_load = 1'b0;
    logic [AW-1:0] mux_addr;
    logic [AW-1:0] wr_addr_log [$];
    logic [DW-1:0] wr_data_log [$];

    always_comb begin
        case (mux_sel)
            2'd0:    mux_addr = addr_a_q;
            2'd1:    mux_addr = addr_b_q;
            default: mux_addr = '0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++)
                mem[i] <= (i == 3) ? 8'h11 : (i == 9) ? 8'h22 : 8'(128 + i);
        end else if (wr_en) begin
            mem[mux_addr] <= wr_data;
            wr_addr_log.push_back(mux_addr);
            wr_data_log.push_back(wr_data);
        end
        rd_data <= mem[mux_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int         done_cyc;
    int         n_done;
    logic       busy_mid;
    logic [1:0] seq [7];
    int         exp_seq [7] = '{2, 0, 1, 1, 0, 1, 2};

    // One swap request; watches 9 cycles after the start edge (bounded, never hangs).
    task automatic run_swap(input logic [AW-1:0] a, input logic [AW-1:0] b, input int glitch_cyc);
        @(negedge clk);
        addr_a = a;
        addr_b = b;
        start  = 1'b1;
        seq[0] = mux_sel;
        done_cyc = -1;
        n_done   = 0;
        busy_mid = 1'b0;
        @(posedge clk);
        #1;
        start  = 1'b0;
        addr_a = '1;
        addr_b = '0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (cyc <= 6) seq[cyc] = mux_sel;
            if (cyc == 3) busy_mid = busy;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == glitch_cyc) begin
                start  = 1'b1;
                addr_a = 5'd0;
                addr_b = 5'd1;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    int base;

    initial begin
        mem_load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mux_sel",  32'(mux_sel),  32'd2);
        check("rst_wr_en",    32'(wr_en),    32'd0);
        check("rst_wr_data",  32'(wr_data),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_swap_cnt", 32'(swap_cnt), 32'd0);
        check("rst_addr_a_q", 32'(addr_a_q), 32'd0);
        check("rst_addr_b_q", 32'(addr_b_q), 32'd0);
        @(negedge clk);
        mem_load = 1'b0;
        rst_n    = 1'b1;

        // Basic swap 3 <-> 9
        base = wr_addr_log.size();
        run_swap(5'd3, 5'd9, 0);
        check("swap1_done_cyc", 32'(done_cyc), 32'd6);
        check("swap1_n_done",   32'(n_done),   32'd1);
        check("swap1_busy",     32'(busy_mid), 32'd1);
        check("swap1_n_wr",     32'(wr_addr_log.size() - base), 32'd2);
        if (wr_addr_log.size() - base == 2) begin
            check("swap1_wr0_addr", 32'(wr_addr_log[base]),     32'd3);
            check("swap1_wr0_data", 32'(wr_data_log[base]),     32'h22);
            check("swap1_wr1_addr", 32'(wr_addr_log[base + 1]), 32'd9);
            check("swap1_wr1_data", 32'(wr_data_log[base + 1]), 32'h11);
        end
        check("swap1_mem3",  32'(mem[3]),   32'h22);
        check("swap1_mem9",  32'(mem[9]),   32'h11);
        check("swap1_cnt",   32'(swap_cnt), 32'd1);
        check("swap1_a_q",   32'(addr_a_q), 32'd3);
        check("swap1_b_q",   32'(addr_b_q), 32'd9);
        check("swap1_idle",  32'(busy),     32'd0);
        check("swap1_wdata", 32'(wr_data),  32'd0);

        // Repeat swap restores memory; mux_sel sequence cycle by cycle
        run_swap(5'd3, 5'd9, 0);
        check("swap2_mem3", 32'(mem[3]),   32'h11);
        check("swap2_mem9", 32'(mem[9]),   32'h22);
        check("swap2_cnt",  32'(swap_cnt), 32'd2);
        for (int i = 0; i < 7; i++)
            check($sformatf("swap2_sel%0d", i), 32'(seq[i]), 32'(exp_seq[i]));

        // Equal addresses: one cycle, no write
        base = wr_addr_log.size();
        run_swap(5'd7, 5'd7, 0);
        check("eq_done_cyc", 32'(done_cyc), 32'd1);
        check("eq_n_done",   32'(n_done),   32'd1);
        check("eq_n_wr",     32'(wr_addr_log.size() - base), 32'd0);
        check("eq_mem7",     32'(mem[7]),   32'h87);
        check("eq_cnt",      32'(swap_cnt), 32'd3);

        // start pulsed during WR_A is ignored
        base = wr_addr_log.size();
        run_swap(5'd4, 5'd5, 4);
        check("glitch_n_done", 32'(n_done),   32'd1);
        check("glitch_n_wr",   32'(wr_addr_log.size() - base), 32'd2);
        check("glitch_mem4",   32'(mem[4]),   32'h85);
        check("glitch_mem5",   32'(mem[5]),   32'h84);
        check("glitch_mem0",   32'(mem[0]),   32'h80);
        check("glitch_mem1",   32'(mem[1]),   32'h81);
        check("glitch_cnt",    32'(swap_cnt), 32'd4);

        // Reset asserted in CAP_B
        base = wr_addr_log.size();
        @(negedge clk);
        addr_a = 5'd10;
        addr_b = 5'd11;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("cap_b_sel", 32'(mux_sel), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_mux_sel",  32'(mux_sel),  32'd2);
        check("abort_wr_en",    32'(wr_en),    32'd0);
        check("abort_wr_data",  32'(wr_data),  32'd0);
        check("abort_busy",     32'(busy),     32'd0);
        check("abort_done",     32'(done),     32'd0);
        check("abort_swap_cnt", 32'(swap_cnt), 32'd0);
        check("abort_addr_a_q", 32'(addr_a_q), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_n_wr",  32'(wr_addr_log.size() - base), 32'd0);
        check("abort_mem10", 32'(mem[10]), 32'h8a);
        check("abort_mem11", 32'(mem[11]), 32'h8b);

        run_swap(5'd10, 5'd11, 0);
        check("post_done_cyc", 32'(done_cyc), 32'd6);
        check("post_mem10",    32'(mem[10]),  32'h8b);
        check("post_mem11",    32'(mem[11]),  32'h8a);
        check("post_cnt",      32'(swap_cnt), 32'd1);

        // Saturation of swap_cnt
        for (int n = 1; n <= 260; n++) begin
            run_swap(5'd1, 5'd2, 0);
            if (n == 253) check("sat_cnt_254", 32'(swap_cnt), 32'd254);
            if (n == 254) check("sat_cnt_255", 32'(swap_cnt), 32'd255);
        end
        check("sat_cnt_hold", 32'(swap_cnt), 32'd255);
        check("sat_mem1",     32'(mem[1]),   32'h81);
        check("sat_mem2",     32'(mem[2]),   32'h82);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
